axi4_lite_sram_slave: RTL and testbench
=======================================

AXI4_LITE_SRAM_SLAVE -- requirements
Module: axi4_lite_sram_slave

Interface
REQ-001 SHALL have parameter MEM_BASE, default 64'h8000_0000: byte address of memory word 0.
REQ-002 SHALL have parameter DEPTH_LOG2, default 12: memory holds 2^DEPTH_LOG2 64-bit words.
REQ-003 SHALL have parameter RD_LAT, default 2, range 0..15: wait cycles between AR handshake and RVALID.
REQ-004 SHALL use one clock and a synchronous, active-low reset.
REQ-005 SHALL have ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-low reset.
- awaddr  input  64  write address.
- awvalid  input  1  write address valid.
- awready  output  1  write address accepted.
- wdata  input  64  write data.
- wstrb  input  8  byte enables; bit i covers wdata[8i+7:8i].
- wvalid  input  1  write data valid.
- wready  output  1  write data accepted.
- bresp  output  2  write response; 00 OKAY, 10 SLVERR.
- bvalid  output  1  write response valid.
- bready  input  1  write response accepted.
- araddr  input  64  read address.
- arvalid  input  1  read address valid.
- arready  output  1  read address accepted.
- rdata  output  64  read data.
- rresp  output  2  read response; 00 OKAY, 10 SLVERR.
- rvalid  output  1  read data valid.
- rready  input  1  read data accepted.

Function
REQ-006 A handshake SHALL occur on a rising edge where valid and ready are both 1; the slave SHALL NOT wait for the master's valid before raising ready.
REQ-007 An address SHALL be in range iff MEM_BASE <= addr < MEM_BASE + 8*2^DEPTH_LOG2. The word index SHALL be (addr - MEM_BASE)[DEPTH_LOG2+2:3]. addr[2:0] SHALL be ignored.
REQ-008 The read FSM SHALL have states R_IDLE, R_WAIT and R_RESP. arready SHALL be 1 only in R_IDLE.
REQ-009 On an AR handshake the FSM SHALL latch araddr and load a down-counter with RD_LAT. It SHALL then enter R_WAIT, or enter R_RESP directly when RD_LAT=0.
REQ-010 R_WAIT SHALL decrement the counter each cycle and SHALL enter R_RESP on the edge where the counter is 1. RVALID SHALL therefore first be high exactly RD_LAT+1 cycles after the AR handshake edge.
REQ-011 On entry to R_RESP, rdata and rresp SHALL be registered. For an in-range address: rdata = memory word, rresp = 00. For an out-of-range address: rdata = 0, rresp = 10.
REQ-012 In R_RESP, rvalid SHALL be 1, and rvalid, rdata and rresp SHALL hold stable until the R handshake. The FSM SHALL return to R_IDLE on the R handshake edge.
REQ-013 The write path SHALL use two flags, aw_got and w_got. awready = !aw_got && !bvalid. wready = !w_got && !bvalid.
REQ-014 The write path SHALL accept AW and W in either order or on the same edge, latching awaddr, wdata and wstrb on their respective handshakes.
REQ-015 On the edge after both flags are set:
- for an in-range address, the memory word SHALL be updated only in the bytes whose wstrb bit is 1;
- for an out-of-range address, memory SHALL be unchanged;
- bvalid SHALL be set, bresp SHALL be set to 00 or 10, and both flags SHALL be cleared.
REQ-016 bvalid and bresp SHALL hold until the B handshake; bvalid SHALL clear on the B handshake edge.
REQ-017 Read and write paths SHALL be independent and able to operate concurrently.
REQ-018 If a write commit and an R_RESP entry to the same word occur on the same edge, rdata SHALL return the pre-write value. A write committed on any earlier edge SHALL be visible to the read.
REQ-019 wstrb = 0 SHALL produce an OKAY response with no memory change.

Reset
REQ-020 While rst=0 at a clock edge, the block SHALL force:
- read FSM to R_IDLE; counter, aw_got, w_got to 0;
- rvalid = 0, bvalid = 0, rdata = 0, rresp = 00, bresp = 00.
REQ-021 After reset, arready, awready and wready SHALL read 1.
REQ-022 Memory contents SHALL NOT be affected by reset.
REQ-023 A transaction in progress when reset is asserted SHALL be discarded with no response issued and no memory write.

Verification
REQ-024 The bench SHALL cover:
- AW+W same cycle, addr 0x8000_0010, wdata 0x1122334455667788, wstrb FF, then AR same addr, RD_LAT=2 -> bvalid next edge with bresp 00; rvalid 3 cycles after AR with rdata 0x1122334455667788, rresp 00.
- W two cycles before AW, wstrb 0x0F, wdata all 0xAA over a word of all 0x00 -> readback 0x00000000AAAAAAAA; awready/wready low while bvalid pending.
- AR to 0x7FFF_FFF8 and to MEM_BASE+8*4096 -> rresp 10, rdata 0; write to 0x7FFF_FFF8 -> bresp 10, memory unchanged.
- rready held low 5 cycles with RD_LAT=0 -> rvalid high 1 cycle after AR and held, rdata stable, arready 0 until the R handshake.
- rst driven low during R_WAIT and with aw_got=1 -> next cycle rvalid=0, bvalid=0, arready=awready=wready=1; no later response appears; memory unchanged.

Source files
------------

// File: rtl/axi4_lite_sram_slave.sv
// AXI4-Lite slave backed by a 64-bit-wide SRAM with a configurable read latency.
// The read and write channels run independently; out-of-range accesses get SLVERR.
module axi4_lite_sram_slave #(
  parameter logic [63:0] MEM_BASE   = 64'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [63:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready
);

  localparam int unsigned DEPTH       = 2 ** DEPTH_LOG2;
  localparam logic [63:0] MEM_BYTES   = 64'd1 << (DEPTH_LOG2 + 3);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;

  logic [63:0] mem [DEPTH];

  rd_state_t             state, state_next;
  logic [3:0]            rd_cnt;
  logic [63:0]           ar_addr_q;
  logic [63:0]           rd_addr, rd_off;
  logic                  rd_in_range, rd_load;
  logic [DEPTH_LOG2-1:0] rd_idx;

  logic                  aw_got, w_got, commit;
  logic [63:0]           aw_addr_q, wdata_q, wr_off;
  logic [7:0]            wstrb_q;
  logic                  wr_in_range;
  logic [DEPTH_LOG2-1:0] wr_idx;

  // With RD_LAT=0 the response is loaded on the AR edge itself, before ar_addr_q is valid.
  assign rd_addr     = (state == R_IDLE) ? araddr : ar_addr_q;
  assign rd_off      = rd_addr - MEM_BASE;
  assign rd_in_range = (rd_addr >= MEM_BASE) && (rd_off < MEM_BYTES);
  assign rd_idx      = rd_off[DEPTH_LOG2+2:3];

  assign wr_off      = aw_addr_q - MEM_BASE;
  assign wr_in_range = (aw_addr_q >= MEM_BASE) && (wr_off < MEM_BYTES);
  assign wr_idx      = wr_off[DEPTH_LOG2+2:3];

  assign arready = (state == R_IDLE);
  assign rvalid  = (state == R_RESP);
  assign rd_load = (state_next == R_RESP) && (state != R_RESP);

  always_ff @(posedge clk) begin
    if (!rst) state <= R_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      R_IDLE:  if (arvalid) state_next = (RD_LAT == 0) ? R_RESP : R_WAIT;
      R_WAIT:  if (rd_cnt == 4'd1) state_next = R_RESP;
      R_RESP:  if (rready) state_next = R_IDLE;
      default: state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_cnt    <= '0;
      ar_addr_q <= '0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
    end else begin
      if (state == R_IDLE && arvalid) begin
        ar_addr_q <= araddr;
        rd_cnt    <= 4'(RD_LAT);
      end else if (state == R_WAIT) begin
        rd_cnt <= rd_cnt - 4'd1;
      end
      if (rd_load) begin
        rdata <= rd_in_range ? mem[rd_idx] : '0;
        rresp <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign awready = !aw_got && !bvalid;
  assign wready  = !w_got && !bvalid;
  assign commit  = aw_got && w_got;

  always_ff @(posedge clk) begin
    if (!rst) begin
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
    end else begin
      if (awvalid && awready) begin
        aw_got    <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (wvalid && wready) begin
        w_got   <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (commit) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        bvalid <= 1'b1;
        bresp  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Storage is never reset; a commit is suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst && commit && wr_in_range) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (wstrb_q[b]) mem[wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_sram_slave.sv
// Directed bench for axi4_lite_sram_slave: one instance with RD_LAT=2, one with RD_LAT=0,
// sharing all inputs so both see identical traffic.
module tb_axi4_lite_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] awaddr, wdata, araddr;
  logic [7:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [63:0] rdata;

  logic        awready_0, wready_0, bvalid_0, arready_0, rvalid_0;
  logic [1:0]  bresp_0, rresp_0;
  logic [63:0] rdata_0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  axi4_lite_sram_slave #(.MEM_BASE(64'h8000_0000), .DEPTH_LOG2(12), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  axi4_lite_sram_slave #(.MEM_BASE(64'h8000_0000), .DEPTH_LOG2(12), .RD_LAT(0)) dut_0 (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready_0),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_0),
    .bresp(bresp_0), .bvalid(bvalid_0), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready_0),
    .rdata(rdata_0), .rresp(rresp_0), .rvalid(rvalid_0), .rready(rready)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // lead > 0: W handshakes lead cycles before AW; lead < 0: AW first; 0: same edge.
  task automatic do_write(input string tag, input logic [63:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, input int lead, input logic [1:0] exp_resp);
    int gap;
    gap = (lead < 0) ? -lead : lead;
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    awvalid = (lead <= 0);
    wvalid  = (lead >= 0);
    if (gap != 0) begin
      @(posedge clk); #1;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      check_eq({tag, "_split_ready"}, {awready, wready}, (lead > 0) ? 2'b10 : 2'b01);
      for (int i = 1; i < gap; i++) begin
        @(posedge clk); #1;
      end
      if (lead > 0) awvalid = 1'b1;
      else          wvalid  = 1'b1;
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check_eq({tag, "_bvalid_early"}, bvalid, 1'b0);
    @(posedge clk); #1;
    check_eq({tag, "_bvalid"}, bvalid, 1'b1);
    check_eq({tag, "_bresp"}, bresp, exp_resp);
    check_eq({tag, "_ready_blocked"}, {awready, wready}, 2'b00);
    @(posedge clk); #1;
    check_eq({tag, "_bvalid_hold"}, {bvalid, bresp}, {1'b1, exp_resp});
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check_eq({tag, "_bvalid_clr"}, bvalid, 1'b0);
    check_eq({tag, "_ready_back"}, {awready, wready}, 2'b11);
  endtask

  task automatic do_read(input string tag, input logic [63:0] addr,
                         input logic [63:0] exp_data, input logic [1:0] exp_resp);
    int unsigned waited;
    waited  = 0;
    araddr  = addr;
    arvalid = 1'b1;
    check_eq({tag, "_arready"}, arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check_eq({tag, "_l0_rvalid"}, rvalid_0, 1'b1);
    check_eq({tag, "_l0_rdata"}, rdata_0, exp_data);
    check_eq({tag, "_l0_rresp"}, rresp_0, exp_resp);
    while (!rvalid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    // Visible just after edge AR+2, so first sampled by the master at AR+3.
    check_eq({tag, "_lat"}, waited, 2);
    check_eq({tag, "_rdata"}, rdata, exp_data);
    check_eq({tag, "_rresp"}, rresp, exp_resp);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check_eq({tag, "_rvalid_clr"}, {rvalid, rvalid_0}, 2'b00);
    check_eq({tag, "_arready_back"}, {arready, arready_0}, 2'b11);
  endtask

  initial begin
    rst = 1'b0;
    awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check_eq("rst_readies", {arready, awready, wready, arready_0, awready_0, wready_0}, 6'h3F);
    check_eq("rst_valids", {rvalid, bvalid, rvalid_0, bvalid_0}, 4'h0);
    check_eq("rst_rdata", rdata, 64'h0);
    check_eq("rst_resps", {rresp, bresp}, 4'h0);

    do_write("w_same", 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, 2'b00);
    do_read("r_same", 64'h8000_0010, 64'h1122_3344_5566_7788, 2'b00);

    do_write("w_zero", 64'h8000_0020, 64'h0, 8'hFF, 0, 2'b00);
    do_write("w_lead2", 64'h8000_0020, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 2, 2'b00);
    do_read("r_lead2", 64'h8000_0020, 64'h0000_0000_AAAA_AAAA, 2'b00);
    do_write("w_awfirst", 64'h8000_0027, 64'h5511_2233_4455_6677, 8'h80, -1, 2'b00);
    do_read("r_awfirst", 64'h8000_0020, 64'h5500_0000_AAAA_AAAA, 2'b00);
    do_write("w_nostrb", 64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 2'b00);
    do_read("r_nostrb", 64'h8000_0020, 64'h5500_0000_AAAA_AAAA, 2'b00);

    do_write("w_last", 64'h8000_7FF8, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 0, 2'b00);
    do_read("r_last", 64'h8000_7FF8, 64'hDEAD_BEEF_0BAD_F00D, 2'b00);
    do_read("r_below", 64'h7FFF_FFF8, 64'h0, 2'b10);
    do_read("r_above", 64'h8000_8000, 64'h0, 2'b10);
    do_write("w_below", 64'h7FFF_FFF8, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 2'b10);
    do_write("w_above", 64'h8000_8000, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 2'b10);
    do_read("r_keep_last", 64'h8000_7FF8, 64'hDEAD_BEEF_0BAD_F00D, 2'b00);
    do_read("r_keep_first", 64'h8000_0000 + 64'h10, 64'h1122_3344_5566_7788, 2'b00);

    // rready held low: RD_LAT=0 instance must hold its response for 5 cycles.
    araddr  = 64'h8000_0010;
    arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_rvalid", rvalid_0, 1'b1);
      check_eq("hold_rdata", rdata_0, 64'h1122_3344_5566_7788);
      check_eq("hold_arready", arready_0, 1'b0);
      @(posedge clk); #1;
    end
    check_eq("hold_main_rvalid", rvalid, 1'b1);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check_eq("hold_release", {rvalid_0, arready_0, rvalid, arready}, 4'b0101);

    // Write commit and R_RESP entry on the same edge in the RD_LAT=2 instance.
    araddr  = 64'h8000_0010;
    arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    awaddr = 64'h8000_0010; wdata = 64'hCAFE_CAFE_CAFE_CAFE; wstrb = 8'hFF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    check_eq("coll_rvalid", rvalid, 1'b1);
    check_eq("coll_bvalid", bvalid, 1'b1);
    check_eq("coll_rdata_old", rdata, 64'h1122_3344_5566_7788);
    rready = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0; bready = 1'b0;
    check_eq("coll_done", {rvalid, bvalid, rvalid_0, bvalid_0}, 4'h0);
    do_read("r_coll_new", 64'h8000_0010, 64'hCAFE_CAFE_CAFE_CAFE, 2'b00);

    // Reset while a read waits and an AW has been accepted without its W.
    do_write("w_pre_rst", 64'h8000_0030, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, 0, 2'b00);
    araddr = 64'h8000_0030; arvalid = 1'b1;
    awaddr = 64'h8000_0030; awvalid = 1'b1;
    wdata  = 64'hFFFF_0000_FFFF_0000; wstrb = 8'hFF;
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0;
    check_eq("mid_awready", awready, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check_eq("mrst_valids", {rvalid, bvalid, rvalid_0, bvalid_0}, 4'h0);
    check_eq("mrst_readies", {arready, awready, wready, arready_0, awready_0, wready_0}, 6'h3F);
    check_eq("mrst_rdata", {rdata, rdata_0}, 128'h0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check_eq("mrst_quiet", {rvalid, bvalid, rvalid_0, bvalid_0}, 4'h0);
    end
    do_read("r_post_rst", 64'h8000_0030, 64'h0F0F_0F0F_0F0F_0F0F, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
